// File: rtl/change_dispenser.sv
// change_dispenser: turns a change amount into a serial stream of coin codes
// on the 2-bit coin bus (00=1, 01=5, 10=10, 11=idle). Coins are picked
// greedily, largest first. Each coin is held for PULSE_CYCLES and followed
// by GAP_CYCLES of idle. Handshake is start/busy/done.
// Optional feature macro: CHANGE_INVENTORY_EN adds per-denomination stock
// counters. With stock enabled, an amount that cannot be paid ends with an
// error pulse, and remaining then holds the shortfall.
module change_dispenser #(
  parameter int AMT_W        = 8,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amount,
  output logic [1:0]       coin_out,
  output logic             coin_strobe,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] coin_count
`ifdef CHANGE_INVENTORY_EN
  ,
  input  logic             inv_load,
  input  logic [7:0]       inv_10,
  input  logic [7:0]       inv_5,
  input  logic [7:0]       inv_1,
  output logic [7:0]       stock_10,
  output logic [7:0]       stock_5,
  output logic [7:0]       stock_1
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0]  CODE_1     = 2'b00;
  localparam logic [1:0]  CODE_5     = 2'b01;
  localparam logic [1:0]  CODE_10    = 2'b10;
  localparam logic [1:0]  CODE_IDLE  = 2'b11;
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  // Value in dong of the coin currently on the bus.
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      CODE_1:  coin_value = AMT_W'(1);
      CODE_5:  coin_value = AMT_W'(5);
      CODE_10: coin_value = AMT_W'(10);
      default: coin_value = {AMT_W{1'b0}};
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       coin_out_q, coin_out_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] coin_count_q, coin_count_d;
  logic             can_10_s, can_5_s, can_1_s;
`ifdef CHANGE_INVENTORY_EN
  logic             error_q, error_d;
  logic [7:0]       stock_10_q, stock_10_d;
  logic [7:0]       stock_5_q, stock_5_d;
  logic [7:0]       stock_1_q, stock_1_d;
`endif

  // Decide which denominations fit in the remaining amount (and are in stock).
  always_comb begin
    can_10_s = (remaining_q >= AMT_W'(10));
    can_5_s  = (remaining_q >= AMT_W'(5));
    can_1_s  = (remaining_q != {AMT_W{1'b0}});
`ifdef CHANGE_INVENTORY_EN
    can_10_s = can_10_s && (stock_10_q != 8'd0);
    can_5_s  = can_5_s  && (stock_5_q  != 8'd0);
    can_1_s  = can_1_s  && (stock_1_q  != 8'd0);
`endif
  end

  // Next-state and next-output logic for the dispense sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    coin_out_d   = coin_out_q;
    strobe_d     = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    remaining_d  = remaining_q;
    coin_count_d = coin_count_q;
`ifdef CHANGE_INVENTORY_EN
    error_d      = 1'b0;
    stock_10_d   = stock_10_q;
    stock_5_d    = stock_5_q;
    stock_1_d    = stock_1_q;
`endif
    case (state_q)
      S_IDLE: begin
        coin_out_d = CODE_IDLE;
        cnt_d      = 16'd0;
`ifdef CHANGE_INVENTORY_EN
        if (inv_load) begin
          stock_10_d = inv_10;
          stock_5_d  = inv_5;
          stock_1_d  = inv_1;
        end else begin
          stock_10_d = stock_10_q;
          stock_5_d  = stock_5_q;
          stock_1_d  = stock_1_q;
        end
`endif
        if (start) begin
          remaining_d  = change_amount;
          coin_count_d = {AMT_W{1'b0}};
          busy_d       = 1'b1;
          if (change_amount == {AMT_W{1'b0}}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SELECT;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_SELECT: begin
        cnt_d = 16'd0;
        if (can_10_s) begin
          coin_out_d = CODE_10;
          strobe_d   = 1'b1;
          state_d    = S_PULSE;
        end else if (can_5_s) begin
          coin_out_d = CODE_5;
          strobe_d   = 1'b1;
          state_d    = S_PULSE;
        end else if (can_1_s) begin
          coin_out_d = CODE_1;
          strobe_d   = 1'b1;
          state_d    = S_PULSE;
        end else begin
          // Nothing payable is left in stock: end with the shortfall owed.
          state_d = S_DONE;
          done_d  = 1'b1;
`ifdef CHANGE_INVENTORY_EN
          error_d = 1'b1;
`endif
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          remaining_d  = remaining_q - coin_value(coin_out_q);
          coin_count_d = coin_count_q + AMT_W'(1);
          coin_out_d   = CODE_IDLE;
          cnt_d        = 16'd0;
          state_d      = S_GAP;
`ifdef CHANGE_INVENTORY_EN
          case (coin_out_q)
            CODE_10: stock_10_d = stock_10_q - 8'd1;
            CODE_5:  stock_5_d  = stock_5_q - 8'd1;
            CODE_1:  stock_1_d  = stock_1_q - 8'd1;
            default: stock_1_d  = stock_1_q;
          endcase
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 16'd0;
          if (remaining_q == {AMT_W{1'b0}}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SELECT;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        coin_out_d = CODE_IDLE;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      coin_out_q   <= CODE_IDLE;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      remaining_q  <= {AMT_W{1'b0}};
      coin_count_q <= {AMT_W{1'b0}};
`ifdef CHANGE_INVENTORY_EN
      error_q      <= 1'b0;
      stock_10_q   <= 8'd0;
      stock_5_q    <= 8'd0;
      stock_1_q    <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      coin_out_q   <= coin_out_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      remaining_q  <= remaining_d;
      coin_count_q <= coin_count_d;
`ifdef CHANGE_INVENTORY_EN
      error_q      <= error_d;
      stock_10_q   <= stock_10_d;
      stock_5_q    <= stock_5_d;
      stock_1_q    <= stock_1_d;
`endif
    end
  end

  assign coin_out    = coin_out_q;
  assign coin_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign remaining   = remaining_q;
  assign coin_count  = coin_count_q;
`ifdef CHANGE_INVENTORY_EN
  assign error    = error_q;
  assign stock_10 = stock_10_q;
  assign stock_5  = stock_5_q;
  assign stock_1  = stock_1_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed tests against a timeline model of the
// dispenser. dut_a uses default timing; dut_b uses PULSE_CYCLES=2, GAP_CYCLES=3.
module tb_change_dispenser;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, a_start, b_start;
  logic [AW-1:0] amt;
  logic [1:0]    a_co, b_co;
  logic          a_st, b_st, a_busy, b_busy, a_done, b_done, a_err, b_err;
  logic [AW-1:0] a_rem, b_rem, a_cnt, b_cnt;
`ifdef CHANGE_INVENTORY_EN
  logic          inv_load;
  logic [7:0]    inv_10, inv_5, inv_1;
  logic [7:0]    a_s10, a_s5, a_s1, b_s10, b_s5, b_s1;
`endif

  change_dispenser #(.AMT_W(AW), .PULSE_CYCLES(1), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .change_amount(amt),
    .coin_out(a_co), .coin_strobe(a_st), .busy(a_busy), .done(a_done),
    .error(a_err), .remaining(a_rem), .coin_count(a_cnt)
`ifdef CHANGE_INVENTORY_EN
    , .inv_load(inv_load), .inv_10(inv_10), .inv_5(inv_5), .inv_1(inv_1),
    .stock_10(a_s10), .stock_5(a_s5), .stock_1(a_s1)
`endif
  );

  change_dispenser #(.AMT_W(AW), .PULSE_CYCLES(2), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .change_amount(amt),
    .coin_out(b_co), .coin_strobe(b_st), .busy(b_busy), .done(b_done),
    .error(b_err), .remaining(b_rem), .coin_count(b_cnt)
`ifdef CHANGE_INVENTORY_EN
    , .inv_load(inv_load), .inv_10(inv_10), .inv_5(inv_5), .inv_1(inv_1),
    .stock_10(b_s10), .stock_5(b_s5), .stock_1(b_s1)
`endif
  );

  int errors = 0;
  int checks = 0;
  int m_len, cyc, done_cyc;
  bit chk_on = 1'b0;
  bit sel = 1'b0;

  logic [1:0] e_co   [0:511];
  bit         e_st   [0:511];
  bit         e_busy [0:511];
  bit         e_done [0:511];
  bit         e_err  [0:511];
  int         e_rem  [0:511];
  int         e_cnt  [0:511];
  logic [1:0] s_codes[$];
  int         s_cycs [$];

  logic [1:0]    m_co;
  logic          m_st, m_busy, m_done, m_err;
  logic [AW-1:0] m_rem, m_cnt;
  assign m_co   = sel ? b_co   : a_co;
  assign m_st   = sel ? b_st   : a_st;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_err  = sel ? b_err  : a_err;
  assign m_rem  = sel ? b_rem  : a_rem;
  assign m_cnt  = sel ? b_cnt  : a_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] code_of(input int v);
    if (v == 10) return 2'b10;
    else if (v == 5) return 2'b01;
    else return 2'b00;
  endfunction

  // Timeline model: greedy coin list, then per-cycle outputs from arithmetic.
  // Cycle 1 follows the start edge. Coin k starts its SELECT cycle at 1+k*C,
  // where C = 1+p+g.
  task automatic build_model(input int a, input int p, input int g,
                             input int s10, input int s5, input int s1, input bit lim);
    int coins[$];
    int rem, n, cc, done_c, paid, kd, off;
    bit stuck;
    rem = a;
    stuck = 1'b0;
    while (rem > 0 && !stuck) begin
      if (rem >= 10 && (!lim || s10 > 0)) begin coins.push_back(10); s10--; rem -= 10; end
      else if (rem >= 5 && (!lim || s5 > 0)) begin coins.push_back(5); s5--; rem -= 5; end
      else if (!lim || s1 > 0) begin coins.push_back(1); s1--; rem -= 1; end
      else stuck = 1'b1;
    end
    n = coins.size();
    cc = 1 + p + g;
    done_c = 1 + n * cc + (stuck ? 1 : 0);
    m_len = done_c + 1;
    for (int c = 1; c <= m_len; c++) begin
      e_busy[c] = (c <= done_c);
      e_done[c] = (c == done_c);
      e_err[c]  = (c == done_c) && stuck;
      e_co[c]   = 2'b11;
      e_st[c]   = 1'b0;
      kd = 0;
      paid = 0;
      for (int k = 0; k < n; k++) begin
        if (c >= 2 + p + k * cc) begin kd++; paid += coins[k]; end
        off = c - (2 + k * cc);
        if (off >= 0 && off < p) begin
          e_co[c] = code_of(coins[k]);
          e_st[c] = (off == 0);
        end
      end
      e_cnt[c] = kd;
      e_rem[c] = a - paid;
    end
  endtask

  // Compare process: checks every output against the model each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk($sformatf("coin_out@%0d", cyc),  32'(m_co),   32'(e_co[cyc]));
        chk($sformatf("strobe@%0d", cyc),    32'(m_st),   32'(e_st[cyc]));
        chk($sformatf("busy@%0d", cyc),      32'(m_busy), 32'(e_busy[cyc]));
        chk($sformatf("done@%0d", cyc),      32'(m_done), 32'(e_done[cyc]));
        chk($sformatf("error@%0d", cyc),     32'(m_err),  32'(e_err[cyc]));
        chk($sformatf("remaining@%0d", cyc), 32'(m_rem),  32'(e_rem[cyc]));
        chk($sformatf("coin_count@%0d", cyc), 32'(m_cnt), 32'(e_cnt[cyc]));
        if (m_st === 1'b1) begin s_codes.push_back(m_co); s_cycs.push_back(cyc); end
        if (m_done === 1'b1) done_cyc = cyc;
        if (cyc >= m_len) chk_on = 1'b0;
        else cyc = cyc + 1;
      end
    end
  end

  // One transaction; rp>0 re-pulses start (amount 5) on cycle rp.
  task automatic run_txn(input bit s, input int a, input int p, input int g,
                         input int s10, input int s5, input int s1, input bit lim, input int rp);
    build_model(a, p, g, s10, s5, s1, lim);
    sel = s;
    s_codes.delete();
    s_cycs.delete();
    done_cyc = -1;
    @(negedge clk);
    amt = AW'(a);
    if (s) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    b_start = 1'b0;
    cyc = 1;
    chk_on = 1'b1;
    if (rp > 0) begin
      repeat (rp) @(negedge clk);
      amt = AW'(5);
      if (s) b_start = 1'b1; else a_start = 1'b1;
      @(posedge clk);
      #1;
      a_start = 1'b0;
      b_start = 1'b0;
    end
    for (int t = 0; t < 1000 && chk_on; t++) @(posedge clk);
    if (chk_on) begin
      chk("timeout_cycle", 32'(cyc), 32'(m_len));
      chk_on = 1'b0;
    end
  endtask

  task automatic chk_codes(input string tag, input int n, input logic [1:0] c0,
                           input logic [1:0] c1, input logic [1:0] c2);
    logic [1:0] exp_c[3];
    exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2;
    chk({tag, "_strobes"}, 32'(s_codes.size()), 32'(n));
    for (int i = 0; i < n && i < 3 && i < s_codes.size(); i++)
      chk($sformatf("%s_code%0d", tag, i), 32'(s_codes[i]), 32'(exp_c[i]));
  endtask

`ifdef CHANGE_INVENTORY_EN
  task automatic load_inv(input int s10, input int s5, input int s1);
    @(negedge clk);
    inv_load = 1'b1;
    inv_10 = 8'(s10); inv_5 = 8'(s5); inv_1 = 8'(s1);
    @(posedge clk);
    #1;
    inv_load = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0; amt = '0;
`ifdef CHANGE_INVENTORY_EN
    inv_load = 1'b0; inv_10 = 8'd0; inv_5 = 8'd0; inv_1 = 8'd0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_coin_out", 32'(a_co), 32'd3);
    chk("rst_b_coin_out", 32'(b_co), 32'd3);
    chk("rst_a_strobe", 32'(a_st), 32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_error", 32'(a_err), 32'd0);
    chk("rst_a_remaining", 32'(a_rem), 32'd0);
    chk("rst_a_count", 32'(a_cnt), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    rst_n = 1'b1;
`ifdef CHANGE_INVENTORY_EN
    load_inv(255, 255, 255);
`endif

    // Amount 16: coins 10,5,1 at cycles 2,5,8; done at 10.
    run_txn(1'b0, 16, 1, 1, 0, 0, 0, 1'b0, 0);
    chk_codes("amt16", 3, 2'b10, 2'b01, 2'b00);
    if (s_cycs.size() == 3) begin
      chk("amt16_strobe_cyc0", 32'(s_cycs[0]), 32'd2);
      chk("amt16_strobe_cyc1", 32'(s_cycs[1]), 32'd5);
      chk("amt16_strobe_cyc2", 32'(s_cycs[2]), 32'd8);
    end else begin
      chk("amt16_strobe_cycles", 32'(s_cycs.size()), 32'd3);
    end
    chk("amt16_done_cycle", 32'(done_cyc), 32'd10);
    chk("amt16_count", 32'(a_cnt), 32'd3);
    chk("amt16_remaining", 32'(a_rem), 32'd0);

    // Amount 0: immediate done, no coins.
    run_txn(1'b0, 0, 1, 1, 0, 0, 0, 1'b0, 0);
    chk("amt0_done_cycle", 32'(done_cyc), 32'd1);
    chk("amt0_strobes", 32'(s_codes.size()), 32'd0);
    chk("amt0_count", 32'(a_cnt), 32'd0);

    // Pulse 2 / gap 3, amount 11: coins 10 then 1; done at 13.
    run_txn(1'b1, 11, 2, 3, 0, 0, 0, 1'b0, 0);
    chk_codes("amt11_p2g3", 2, 2'b10, 2'b00, 2'b11);
    chk("amt11_done_cycle", 32'(done_cyc), 32'd13);

    // start re-pulsed while busy: ignored.
    run_txn(1'b0, 20, 1, 1, 0, 0, 0, 1'b0, 3);
    chk_codes("amt20_repulse", 2, 2'b10, 2'b10, 2'b11);
    chk("amt20_remaining", 32'(a_rem), 32'd0);

    // start on the done cycle: ignored.
    run_txn(1'b0, 10, 1, 1, 0, 0, 0, 1'b0, 4);
    chk("amt10_done_cycle", 32'(done_cyc), 32'd4);
    chk("amt10_idle_after", 32'(a_busy), 32'd0);

    // Reset during the 2nd coin of amount 16.
    sel = 1'b0;
    @(negedge clk);
    amt = AW'(16);
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_second_coin", 32'(a_co), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_coin_out", 32'(a_co), 32'd3);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    chk("midrst_done", 32'(a_done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_done_after", 32'(a_done), 32'd0);
    chk("midrst_remaining", 32'(a_rem), 32'd0);
`ifdef CHANGE_INVENTORY_EN
    load_inv(255, 255, 255);
`endif
    run_txn(1'b0, 7, 1, 1, 0, 0, 0, 1'b0, 0);
    chk_codes("amt7_after_rst", 3, 2'b01, 2'b00, 2'b00);

    // Maximum amount: 25 tens + one five.
    run_txn(1'b0, 255, 1, 1, 0, 0, 0, 1'b0, 0);
    chk("amt255_count", 32'(a_cnt), 32'd26);
    chk("amt255_done_cycle", 32'(done_cyc), 32'd79);

    run_txn(1'b1, 14, 2, 3, 0, 0, 0, 1'b0, 0);
    chk("amt14_p2g3_count", 32'(b_cnt), 32'd5);

`ifdef CHANGE_INVENTORY_EN
    // Limited stock: 10:0, 5:1, 1:2, amount 8 -> 5,1,1 then error, shortfall 1.
    load_inv(0, 1, 2);
    run_txn(1'b0, 8, 1, 1, 0, 1, 2, 1'b1, 0);
    chk_codes("inv8", 3, 2'b01, 2'b00, 2'b00);
    chk("inv8_done_cycle", 32'(done_cyc), 32'd11);
    chk("inv8_remaining", 32'(a_rem), 32'd1);
    chk("inv8_stock_10", 32'(a_s10), 32'd0);
    chk("inv8_stock_5", 32'(a_s5), 32'd0);
    chk("inv8_stock_1", 32'(a_s1), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
